// File: rtl/mem_port_arb_if.sv
// Requester, response and memory-port signals of mem_port_arb, grouped per side.
// The arbiter connects through the slave modport; requesters plus memory use master.
interface mem_port_arb_if #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
);
    logic [NCH-1:0]        req_valid;
    logic [NCH-1:0]        req_ready;
    logic [NCH-1:0]        req_wr;
    logic [NCH*AW-1:0]     req_addr;
    logic [NCH*DW-1:0]     req_wdata;
    logic [NCH*DW/8-1:0]   req_wstrb;

    logic [NCH-1:0]        resp_valid;
    logic [NCH-1:0]        resp_ready;
    logic [DW-1:0]         resp_rdata;

    logic                  mem_en;
    logic                  mem_wr;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic [DW/8-1:0]       mem_wstrb;
    logic [DW-1:0]         mem_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_wstrb, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, mem_en, mem_wr, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_wstrb, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, mem_en, mem_wr, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_port_arb.sv
// Round-robin arbiter sharing one fixed-latency memory port among NCH requesters,
// with exactly one transaction outstanding at a time.
module mem_port_arb #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 1
) (
    input logic           clock,
    input logic           reset,
    mem_port_arb_if.slave bus
);
    localparam int         CHW     = (NCH > 2) ? 2 : 1;
    localparam int         SW      = DW / 8;
    localparam logic [2:0] LAT_CNT = 3'(LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CHW-1:0] last_q, last_d;
    logic [CHW-1:0] chan_q, chan_d;
    logic           wr_q, wr_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [DW-1:0]  rdata_q, rdata_d;

    logic           grant_hit;
    logic           grant;
    logic [CHW-1:0] grant_idx;
    logic           sel_wr;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;
    logic [SW-1:0]  sel_wstrb;
    logic           resp_ack;

    // Search offsets from farthest to nearest so the channel right after last_q wins.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int k = NCH; k >= 1; k--) begin
            for (int c = 0; c < NCH; c++) begin
                if (bus.req_valid[c] && (c == (int'(last_q) + k) % NCH)) begin
                    grant_hit = 1'b1;
                    grant_idx = CHW'(c);
                end
            end
        end
    end

    // Reset gates the grant so nothing is accepted while reset is held low.
    assign grant = grant_hit && (state_q == IDLE) && reset;

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int c = 0; c < NCH; c++) begin
            if (CHW'(c) == grant_idx) begin
                sel_wr    = bus.req_wr[c];
                sel_addr  = bus.req_addr[c*AW +: AW];
                sel_wdata = bus.req_wdata[c*DW +: DW];
                sel_wstrb = bus.req_wstrb[c*SW +: SW];
            end
        end
    end

    always_comb begin
        resp_ack = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (CHW'(c) == chan_q) begin
                resp_ack = bus.resp_ready[c];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= CHW'(NCH - 1);
            chan_q  <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= 3'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            chan_q  <= chan_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Count 1 in WAIT is the cycle mem_rdata is valid for the outstanding read.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        chan_d  = chan_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = WAIT;
                    last_d  = grant_idx;
                    chan_d  = grant_idx;
                    wr_d    = sel_wr;
                    cnt_d   = LAT_CNT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = RESP;
                    rdata_d = wr_q ? '0 : bus.mem_rdata;
                end
            end
            RESP: begin
                if (resp_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        bus.mem_en     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_wstrb  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (grant && (CHW'(c) == grant_idx)) begin
                bus.req_ready[c] = 1'b1;
            end
            if ((state_q == RESP) && (CHW'(c) == chan_q)) begin
                bus.resp_valid[c] = 1'b1;
            end
        end
        if (grant) begin
            bus.mem_en    = 1'b1;
            bus.mem_wr    = sel_wr;
            bus.mem_addr  = sel_addr;
            bus.mem_wdata = sel_wdata;
            bus.mem_wstrb = sel_wstrb;
        end
    end

    assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: a LAT=1 instance driven from a cycle table,
// and a LAT=3 instance exercising response back-pressure and mid-transaction reset.
module tb_mem_port_arb;
    localparam logic [31:0] D0  = 32'h1111_1111;
    localparam logic [3:0]  S0  = 4'hF;
    localparam logic [31:0] D1  = 32'hDEAD_BEEF;
    localparam logic [3:0]  S1  = 4'h3;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    mem_port_arb_if #(.NCH(2), .AW(32), .DW(32)) bus1 ();
    mem_port_arb_if #(.NCH(2), .AW(32), .DW(32)) bus3 ();

    mem_port_arb #(.NCH(2), .AW(32), .DW(32), .LAT(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    mem_port_arb #(.NCH(2), .AW(32), .DW(32), .LAT(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] memData(input logic [31:0] addr);
        if (addr == 32'h8000_0000) return 32'h1234_5678;
        return addr ^ 32'h5A5A_A5A5;
    endfunction

    // Memory models: read data appears only in the cycle LAT edges after mem_en.
    logic        p1_v;
    logic [31:0] p1_a;
    always @(posedge clock) begin
        p1_v <= bus1.mem_en && !bus1.mem_wr;
        p1_a <= bus1.mem_addr;
    end
    assign bus1.mem_rdata = p1_v ? memData(p1_a) : BAD;

    logic [2:0]  p3_v;
    logic [31:0] p3_a0, p3_a1, p3_a2;
    always @(posedge clock) begin
        p3_v  <= {p3_v[1:0], bus3.mem_en && !bus3.mem_wr};
        p3_a0 <= bus3.mem_addr;
        p3_a1 <= p3_a0;
        p3_a2 <= p3_a1;
    end
    assign bus3.mem_rdata = p3_v[2] ? memData(p3_a2) : BAD;

    typedef struct {
        logic [1:0]  rv, wr, rr;
        logic [31:0] a0, a1;
        logic [1:0]  e_rdy, e_rsv;
        logic        e_men, e_mwr;
        logic [31:0] e_maddr, e_mwd;
        logic [3:0]  e_mws;
        logic [31:0] e_rsd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] rv, input logic [1:0] wr, input logic [1:0] rr,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [1:0] rdy, input logic [1:0] rsv,
                                input logic men, input logic mwr, input logic [31:0] maddr,
                                input logic [31:0] mwd, input logic [3:0] mws, input logic [31:0] rsd);
        vec_t v;
        v.rv = rv; v.wr = wr; v.rr = rr; v.a0 = a0; v.a1 = a1;
        v.e_rdy = rdy; v.e_rsv = rsv; v.e_men = men; v.e_mwr = mwr;
        v.e_maddr = maddr; v.e_mwd = mwd; v.e_mws = mws; v.e_rsd = rsd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus1.req_valid  = v.rv;
        bus1.req_wr     = v.wr;
        bus1.resp_ready = v.rr;
        bus1.req_addr   = {v.a1, v.a0};
        bus1.req_wdata  = {D1, D0};
        bus1.req_wstrb  = {S1, S0};
    endtask

    task automatic step3(input logic [1:0] rv, input logic [1:0] rr, input logic [31:0] a0, input logic [31:0] a1);
        @(posedge clock);
        #1;
        bus3.req_valid  = rv;
        bus3.resp_ready = rr;
        bus3.req_addr   = {a1, a0};
        @(negedge clock);
    endtask

    task automatic chk3(input string tag, input int idx, input logic [1:0] rdy, input logic [1:0] rsv,
                        input logic men, input logic [31:0] maddr, input logic [31:0] rsd);
        checkOutput({tag, "_rdy"},   idx, 32'(bus3.req_ready),  32'(rdy));
        checkOutput({tag, "_rsv"},   idx, 32'(bus3.resp_valid), 32'(rsv));
        checkOutput({tag, "_men"},   idx, 32'(bus3.mem_en),     32'(men));
        checkOutput({tag, "_maddr"}, idx, bus3.mem_addr,        maddr);
        checkOutput({tag, "_rsd"},   idx, bus3.resp_rdata,      rsd);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus1.req_valid = '0; bus1.req_wr = '0; bus1.resp_ready = '0;
        bus1.req_addr = '0; bus1.req_wdata = '0; bus1.req_wstrb = '0;
        bus3.req_valid = '0; bus3.req_wr = '0; bus3.resp_ready = '0;
        bus3.req_addr = '0; bus3.req_wdata = {D1, D0}; bus3.req_wstrb = {S1, S0};

        //      rv     wr     rr     a0            a1       | rdy    rsv    men  mwr  maddr         mwd    mws   rsd
        vecs.push_back(mk(2'b01, 2'b00, 2'b00, 32'h8000_0000, 32'h0,  2'b01, 2'b00, 1, 0, 32'h8000_0000, D0,   S0,   32'h0));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 32'h8000_0000, 32'h0,  2'b00, 2'b00, 0, 0, 32'h0,         32'h0, 4'h0, 32'h0));
        vecs.push_back(mk(2'b00, 2'b00, 2'b10, 32'h8000_0000, 32'h0,  2'b00, 2'b01, 0, 0, 32'h0,         32'h0, 4'h0, 32'h1234_5678));
        vecs.push_back(mk(2'b10, 2'b10, 2'b01, 32'h8000_0000, 32'h10, 2'b00, 2'b01, 0, 0, 32'h0,         32'h0, 4'h0, 32'h1234_5678));
        vecs.push_back(mk(2'b10, 2'b10, 2'b00, 32'h8000_0000, 32'h10, 2'b10, 2'b00, 1, 1, 32'h10,        D1,    S1,   32'h1234_5678));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 32'h8000_0000, 32'h10, 2'b00, 2'b00, 0, 0, 32'h0,         32'h0, 4'h0, 32'h1234_5678));
        vecs.push_back(mk(2'b00, 2'b00, 2'b10, 32'h8000_0000, 32'h10, 2'b00, 2'b10, 0, 0, 32'h0,         32'h0, 4'h0, 32'h0));
        vecs.push_back(mk(2'b11, 2'b00, 2'b11, 32'h100,       32'h200, 2'b01, 2'b00, 1, 0, 32'h100,      D0,    S0,   32'h0));
        vecs.push_back(mk(2'b11, 2'b00, 2'b11, 32'h100,       32'h200, 2'b00, 2'b00, 0, 0, 32'h0,        32'h0, 4'h0, 32'h0));
        vecs.push_back(mk(2'b11, 2'b00, 2'b11, 32'h100,       32'h200, 2'b00, 2'b01, 0, 0, 32'h0,        32'h0, 4'h0, 32'h5A5A_A4A5));
        vecs.push_back(mk(2'b11, 2'b00, 2'b11, 32'h100,       32'h200, 2'b10, 2'b00, 1, 0, 32'h200,      D1,    S1,   32'h5A5A_A4A5));
        vecs.push_back(mk(2'b11, 2'b00, 2'b11, 32'h300,       32'h200, 2'b00, 2'b00, 0, 0, 32'h0,        32'h0, 4'h0, 32'h5A5A_A4A5));
        vecs.push_back(mk(2'b11, 2'b00, 2'b11, 32'h300,       32'h200, 2'b00, 2'b10, 0, 0, 32'h0,        32'h0, 4'h0, 32'h5A5A_A7A5));
        vecs.push_back(mk(2'b11, 2'b00, 2'b11, 32'h300,       32'h200, 2'b01, 2'b00, 1, 0, 32'h300,      D0,    S0,   32'h5A5A_A7A5));
        vecs.push_back(mk(2'b00, 2'b00, 2'b11, 32'h300,       32'h200, 2'b00, 2'b00, 0, 0, 32'h0,        32'h0, 4'h0, 32'h5A5A_A7A5));
        vecs.push_back(mk(2'b00, 2'b00, 2'b11, 32'h300,       32'h200, 2'b00, 2'b01, 0, 0, 32'h0,        32'h0, 4'h0, 32'h5A5A_A6A5));
        vecs.push_back(mk(2'b00, 2'b00, 2'b00, 32'h300,       32'h200, 2'b00, 2'b00, 0, 0, 32'h0,        32'h0, 4'h0, 32'h5A5A_A6A5));

        // Requests pending while reset is low must not be granted.
        repeat (2) @(posedge clock);
        #1;
        bus1.req_valid = 2'b11;
        bus3.req_valid = 2'b11;
        #1;
        checkOutput("rst_rdy1", 0, 32'(bus1.req_ready),  32'h0);
        checkOutput("rst_men1", 0, 32'(bus1.mem_en),     32'h0);
        checkOutput("rst_rsv1", 0, 32'(bus1.resp_valid), 32'h0);
        checkOutput("rst_rsd1", 0, bus1.resp_rdata,      32'h0);
        chk3("rst3", 0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        bus1.req_valid = '0;
        bus3.req_valid = '0;
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clock);
            #1;
            applyStimulus(vecs[i]);
            @(negedge clock);
            checkOutput("rdy",   i, 32'(bus1.req_ready),  32'(vecs[i].e_rdy));
            checkOutput("rsv",   i, 32'(bus1.resp_valid), 32'(vecs[i].e_rsv));
            checkOutput("men",   i, 32'(bus1.mem_en),     32'(vecs[i].e_men));
            checkOutput("mwr",   i, 32'(bus1.mem_wr),     32'(vecs[i].e_mwr));
            checkOutput("maddr", i, bus1.mem_addr,        vecs[i].e_maddr);
            checkOutput("mwd",   i, bus1.mem_wdata,       vecs[i].e_mwd);
            checkOutput("mws",   i, 32'(bus1.mem_wstrb),  32'(vecs[i].e_mws));
            checkOutput("rsd",   i, bus1.resp_rdata,      vecs[i].e_rsd);
        end

        // LAT=3: grant, three WAIT cycles, then five cycles of back-pressure.
        step3(2'b01, 2'b00, 32'h100, 32'h200);
        chk3("l3_grant", 0, 2'b01, 2'b00, 1'b1, 32'h100, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            step3(2'b11, 2'b00, 32'h100, 32'h200);
            chk3("l3_wait", i, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        end
        for (int i = 4; i <= 8; i++) begin
            step3(2'b11, 2'b00, 32'h100, 32'h200);
            chk3("l3_hold", i, 2'b00, 2'b01, 1'b0, 32'h0, 32'h5A5A_A4A5);
        end
        step3(2'b11, 2'b01, 32'h100, 32'h200);
        chk3("l3_ack", 9, 2'b00, 2'b01, 1'b0, 32'h0, 32'h5A5A_A4A5);
        step3(2'b11, 2'b00, 32'h100, 32'h200);
        chk3("l3_next", 10, 2'b10, 2'b00, 1'b1, 32'h200, 32'h5A5A_A4A5);

        // Reset in WAIT aborts channel 1's read; channel 0 wins after release.
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk3("rst_wait", 11, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int i = 12; i <= 13; i++) begin
            step3(2'b11, 2'b00, 32'h100, 32'h200);
            chk3("rst_hold", i, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        end
        reset = 1'b1;
        #1;
        chk3("rst_rel", 13, 2'b01, 2'b00, 1'b1, 32'h100, 32'h0);
        for (int i = 14; i <= 16; i++) begin
            step3(2'b00, 2'b00, 32'h100, 32'h200);
            chk3("rel_wait", i, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
        end
        step3(2'b00, 2'b01, 32'h100, 32'h200);
        chk3("rel_resp", 17, 2'b00, 2'b01, 1'b0, 32'h0, 32'h5A5A_A4A5);
        step3(2'b00, 2'b00, 32'h100, 32'h200);
        chk3("rel_idle", 18, 2'b00, 2'b00, 1'b0, 32'h0, 32'h5A5A_A4A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
